// File: rtl/l1_wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between NUM_REQ L1 requesters.
// One transaction in flight; reads may be incrementing bursts, writes are single-beat.
module l1_wishbone_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_request,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_rnw,
  input  logic [NUM_REQ*4-1:0]  req_be,
  input  logic [NUM_REQ*5-1:0]  req_size,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [31:0]           ret_data,
  output logic [NUM_REQ-1:0]    ret_data_valid,
  output logic [NUM_REQ-1:0]    ret_err,
  output logic [29:0]           wb_adr,
  output logic [31:0]           wb_dat_w,
  output logic [3:0]            wb_sel,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [2:0]            wb_cti,
  output logic [1:0]            wb_bte,
  input  logic [31:0]           wb_dat_r,
  input  logic                  wb_ack,
  input  logic                  wb_err
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic {IDLE, XFER} state_t;

  state_t               r_state;
  logic [ID_W-1:0]      r_rr;
  logic [ID_W-1:0]      r_gnt;
  logic [NUM_REQ-1:0]   r_ack;
  logic [NUM_REQ-1:0]   r_valid;
  logic [NUM_REQ-1:0]   r_err;
  logic [31:0]          r_ret_data;
  logic [29:0]          r_adr;
  logic [31:0]          r_dat;
  logic [3:0]           r_sel;
  logic                 r_cyc;
  logic                 r_we;
  logic                 r_rnw;
  logic [2:0]           r_cti;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_found;
  logic [ID_W-1:0]      w_gnt;
  int unsigned          w_idx;
  logic [31:0]          w_addr;
  logic [31:0]          w_data;
  logic [3:0]           w_be;
  logic [CNT_W-1:0]     w_size;
  logic                 w_rnw;
  logic [NUM_REQ-1:0]   w_cur_oh;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = 32'(r_rr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req_request[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_addr   = req_addr[32*w_gnt +: 32];
  assign w_data   = req_data[32*w_gnt +: 32];
  assign w_be     = req_be[4*w_gnt +: 4];
  assign w_size   = req_size[CNT_W*w_gnt +: CNT_W];
  assign w_rnw    = req_rnw[w_gnt];
  assign w_cur_oh = NUM_REQ'(1) << r_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr       <= ID_W'(NUM_REQ - 1);
      r_gnt      <= '0;
      r_ack      <= '0;
      r_valid    <= '0;
      r_err      <= '0;
      r_ret_data <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_sel      <= '0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_rnw      <= 1'b0;
      r_cti      <= '0;
      r_cnt      <= '0;
    end else begin
      r_ack   <= '0;
      r_valid <= '0;
      r_err   <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt   <= w_gnt;
            r_rr    <= w_gnt;
            r_ack   <= NUM_REQ'(1) << w_gnt;
            r_adr   <= w_addr[31:2];
            r_dat   <= w_data;
            r_rnw   <= w_rnw;
            r_we    <= ~w_rnw;
            r_sel   <= w_rnw ? 4'hF : w_be;
            r_cnt   <= w_rnw ? w_size : CNT_W'(0);
            r_cti   <= (w_rnw && (w_size != CNT_W'(0))) ? 3'b010 : 3'b111;
            r_cyc   <= 1'b1;
            r_state <= XFER;
          end
        end
        XFER: begin
          // Error wins over a simultaneous ack and suppresses the data beat.
          if (wb_err) begin
            r_err   <= w_cur_oh;
            r_cyc   <= 1'b0;
            r_state <= IDLE;
          end else if (wb_ack) begin
            if (r_rnw) begin
              r_ret_data <= wb_dat_r;
              r_valid    <= w_cur_oh;
            end
            if (r_cnt == CNT_W'(0)) begin
              r_cyc   <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
              r_adr <= r_adr + 30'd1;
              if (r_cnt == CNT_W'(1)) r_cti <= 3'b111;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ack        = r_ack;
  assign ret_data       = r_ret_data;
  assign ret_data_valid = r_valid;
  assign ret_err        = r_err;
  assign wb_adr         = r_adr;
  assign wb_dat_w       = r_dat;
  assign wb_sel         = r_sel;
  assign wb_cyc         = r_cyc;
  assign wb_stb         = r_cyc;
  assign wb_we          = r_we;
  assign wb_cti         = r_cti;
  assign wb_bte         = 2'b00;

endmodule

// File: tb/tb_l1_wishbone_arbiter.sv
// Directed bench for l1_wishbone_arbiter with a scoreboard of expected return pulses.
module tb_l1_wishbone_arbiter;
  localparam int unsigned NUM_REQ = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_request;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_rnw;
  logic [NUM_REQ*4-1:0]  req_be;
  logic [NUM_REQ*5-1:0]  req_size;
  logic [NUM_REQ-1:0]    req_ack;
  logic [31:0]           ret_data;
  logic [NUM_REQ-1:0]    ret_data_valid;
  logic [NUM_REQ-1:0]    ret_err;
  logic [29:0]           wb_adr;
  logic [31:0]           wb_dat_w;
  logic [3:0]            wb_sel;
  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [2:0]            wb_cti;
  logic [1:0]            wb_bte;
  logic [31:0]           wb_dat_r;
  logic                  wb_ack;
  logic                  wb_err;

  l1_wishbone_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_request(req_request), .req_addr(req_addr), .req_data(req_data),
    .req_rnw(req_rnw), .req_be(req_be), .req_size(req_size),
    .req_ack(req_ack), .ret_data(ret_data), .ret_data_valid(ret_data_valid),
    .ret_err(ret_err), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_cti(wb_cti),
    .wb_bte(wb_bte), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  v;
    logic [1:0]  e;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic rnw, input logic [3:0] be, input logic [4:0] sz);
    req_request[i]      = r;
    req_addr[i*32 +: 32] = a;
    req_data[i*32 +: 32] = d;
    req_rnw[i]          = rnw;
    req_be[i*4 +: 4]    = be;
    req_size[i*5 +: 5]  = sz;
  endtask

  task automatic push(input logic [1:0] v, input logic [1:0] e, input logic [31:0] d);
    exp_t x;
    x.v = v; x.e = e; x.d = d;
    q.push_back(x);
  endtask

  task automatic wait_ack(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 20; i++) begin
      if (req_ack != 0) break;
      tick();
    end
    chk(tag, 64'(req_ack), 64'(exp));
  endtask

  // Slave beat: wait for the strobe, insert wait states, check address/cti, respond.
  task automatic slave_beat(input string tag, input logic [31:0] d, input int waits,
                            input logic a, input logic e,
                            input logic [29:0] xadr, input logic [2:0] xcti);
    for (int i = 0; i < 20; i++) begin
      if (wb_cyc && wb_stb) break;
      tick();
    end
    chk({tag, "_stb"}, 64'({wb_cyc, wb_stb}), 64'(2'b11));
    repeat (waits) tick();
    chk({tag, "_adr"}, 64'(wb_adr), 64'(xadr));
    chk({tag, "_cti"}, 64'(wb_cti), 64'(xcti));
    wb_dat_r = d; wb_ack = a; wb_err = e;
    tick();
    wb_ack = 1'b0; wb_err = 1'b0;
  endtask

  // Every return pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (ret_data_valid != 0 || ret_err != 0)) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", 64'({ret_data_valid, ret_err}), 64'(0));
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("sb_ret", {28'd0, ret_data_valid, ret_err, (ret_data_valid != 0) ? ret_data : 32'd0},
            {28'd0, x.v, x.e, x.d});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_request = '0; req_addr = '0; req_data = '0; req_rnw = '0; req_be = '0; req_size = '0;
    wb_dat_r = '0; wb_ack = 1'b0; wb_err = 1'b0;
    tick(); tick();
    chk("rst_outs", {wb_adr, wb_cyc, wb_stb, wb_we, wb_cti, wb_bte, wb_sel, req_ack},
        64'd0);
    chk("rst_ret", 64'({ret_data, ret_data_valid, ret_err}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single read from requester 0 with two wait states.
    set_req(0, 1'b1, 32'h0000_1004, 32'h0, 1'b1, 4'h0, 5'd0);
    wait_ack("rd_ack", 2'b01);
    set_req(0, 1'b0, 32'h0000_1004, 32'h0, 1'b1, 4'h0, 5'd0);
    chk("rd_bus", 64'({wb_cyc, wb_we, wb_sel}), 64'({1'b1, 1'b0, 4'hF}));
    push(2'b01, 2'b00, 32'hDEADBEEF);
    slave_beat("rd", 32'hDEADBEEF, 2, 1'b1, 1'b0, 30'h401, 3'b111);
    chk("rd_cyc_drop", 64'(wb_cyc), 64'd0);
    tick();

    // Write from requester 1: silent completion.
    set_req(1, 1'b1, 32'h20, 32'h12345678, 1'b0, 4'b0011, 5'd7);
    wait_ack("wr_ack", 2'b10);
    set_req(1, 1'b0, 32'h20, 32'h12345678, 1'b0, 4'b0011, 5'd7);
    chk("wr_bus", {26'd0, wb_we, wb_sel, wb_dat_w, 1'b0}, {26'd0, 1'b1, 4'b0011, 32'h12345678, 1'b0});
    slave_beat("wr", 32'h0, 1, 1'b1, 1'b0, 30'h8, 3'b111);
    chk("wr_cyc_drop", 64'(wb_cyc), 64'd0);
    tick(); tick();

    // Four-beat read burst.
    set_req(0, 1'b1, 32'h100, 32'h0, 1'b1, 4'h0, 5'd3);
    wait_ack("bu_ack", 2'b01);
    set_req(0, 1'b0, 32'h100, 32'h0, 1'b1, 4'h0, 5'd3);
    for (int i = 0; i < 4; i++) push(2'b01, 2'b00, 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++)
      slave_beat("bu", 32'hA0 + 32'(i), i % 2, 1'b1, 1'b0, 30'h40 + 30'(i),
                 (i == 3) ? 3'b111 : 3'b010);
    chk("bu_cyc_drop", 64'(wb_cyc), 64'd0);
    tick(); tick();

    // Both requesters hold requests from reset: alternate with one idle cycle between.
    rst_n = 1'b0;
    set_req(0, 1'b1, 32'h0, 32'h0, 1'b1, 4'h0, 5'd0);
    set_req(1, 1'b1, 32'h4, 32'h0, 1'b1, 4'h0, 5'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        wait_ack("rr_ack", 2'b01);
      end else begin
        chk("rr_idle", 64'({wb_cyc, req_ack}), 64'd0);
        tick();
        chk("rr_ack", 64'(req_ack), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
      end
      push((i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 32'hB0 + 32'(i));
      slave_beat("rr", 32'hB0 + 32'(i), 0, 1'b1, 1'b0, 30'(i % 2), 3'b111);
    end
    req_request = '0;
    tick(); tick();

    // Burst aborted by an error coinciding with ack on beat 2.
    set_req(0, 1'b1, 32'h200, 32'h0, 1'b1, 4'h0, 5'd3);
    wait_ack("er_ack", 2'b01);
    set_req(0, 1'b0, 32'h200, 32'h0, 1'b1, 4'h0, 5'd3);
    push(2'b01, 2'b00, 32'hC0);
    push(2'b00, 2'b01, 32'h0);
    slave_beat("er1", 32'hC0, 0, 1'b1, 1'b0, 30'h80, 3'b010);
    slave_beat("er2", 32'hC1, 0, 1'b1, 1'b1, 30'h81, 3'b010);
    chk("er_cyc_drop", 64'(wb_cyc), 64'd0);
    tick(); tick();
    chk("er_no_more", 64'({wb_cyc, wb_stb}), 64'd0);
    set_req(0, 1'b1, 32'h300, 32'h0, 1'b1, 4'h0, 5'd0);
    wait_ack("er_next_ack", 2'b01);
    set_req(0, 1'b0, 32'h300, 32'h0, 1'b1, 4'h0, 5'd0);
    push(2'b01, 2'b00, 32'hC5);
    slave_beat("er_next", 32'hC5, 0, 1'b1, 1'b0, 30'hC0, 3'b111);
    tick(); tick();

    // Reset in the middle of a burst from requester 1.
    set_req(1, 1'b1, 32'h400, 32'h0, 1'b1, 4'h0, 5'd3);
    wait_ack("mr_ack", 2'b10);
    set_req(1, 1'b0, 32'h400, 32'h0, 1'b1, 4'h0, 5'd3);
    push(2'b10, 2'b00, 32'hD0);
    slave_beat("mr", 32'hD0, 0, 1'b1, 1'b0, 30'h100, 3'b010);
    tick();
    chk("mr_cyc_before", 64'(wb_cyc), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_async", 64'({wb_cyc, wb_stb, req_ack, ret_data_valid, ret_err}), 64'd0);
    set_req(0, 1'b1, 32'h500, 32'h0, 1'b1, 4'h0, 5'd0);
    set_req(1, 1'b1, 32'h600, 32'h0, 1'b1, 4'h0, 5'd0);
    tick();
    rst_n = 1'b1;
    wait_ack("mr_first", 2'b01);
    req_request = '0;
    push(2'b01, 2'b00, 32'hE0);
    slave_beat("mr_after", 32'hE0, 0, 1'b1, 1'b0, 30'h140, 3'b111);
    tick(); tick();

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l1_wishbone_arbiter.md
Name: l1_wishbone_arbiter

Overview:
- Shares one Wishbone master port between NUM_REQ L1 requesters, each using the l1 arbiter request/return signal set flattened into packed-array ports.
- Round-robin arbitration; one transaction in flight at a time.
- Reads may be single-beat or incrementing bursts; writes are single-beat.
- Sits between the L1 caches/uncached path and the external Wishbone bus.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, $clog2(NUM_REQ) (min 1), width of grant index

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
req_request  input  NUM_REQ  per-requester request valid
req_addr  input  NUM_REQ*32  byte address, slice i = requester i
req_data  input  NUM_REQ*32  write data
req_rnw  input  NUM_REQ  1 = read, 0 = write
req_be  input  NUM_REQ*4  byte enables (writes)
req_size  input  NUM_REQ*5  read burst length minus 1 (beats = size+1); ignored for writes
req_ack  output  NUM_REQ  one-cycle accept pulse to granted requester
ret_data  output  32  read data, shared by all requesters
ret_data_valid  output  NUM_REQ  one-hot read beat valid
ret_err  output  NUM_REQ  one-hot bus error pulse
wb_adr  output  30  word address
wb_dat_w  output  32  write data
wb_sel  output  4  byte select
wb_cyc  output  1  cycle
wb_stb  output  1  strobe
wb_we  output  1  write enable
wb_cti  output  3  cycle type identifier
wb_bte  output  2  burst type extension, tied 2'b00 (linear)
wb_dat_r  input  32  read data
wb_ack  input  1  acknowledge
wb_err  input  1  error

Behaviour:
- Reset (async, rst_n low):
  - all outputs 0; state IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset asserted mid-transfer drops wb_cyc/wb_stb immediately, with no completion to the requester.
- States: IDLE, XFER.
- IDLE:
  - If any req_request is set, grant the first set bit searching from (rr pointer + 1) mod NUM_REQ upward with wrap.
  - Same cycle: pulse req_ack[g]; latch addr[31:2], data, be, rnw, size; set rr pointer = g; go XFER.
  - No request: stay IDLE.
  - A requester must hold its request fields stable until req_ack.
- XFER (entered the cycle after the grant):
  - wb_cyc = wb_stb = 1; wb_adr = latched word address; wb_we = ~rnw.
  - wb_sel = be for writes, 4'hF for reads; wb_dat_w = latched data.
- Burst counter: loaded with size on grant (writes: 0); beats remaining = cnt+1.
- wb_cti:
  - 3'b111 when cnt==0 (single transfer or final beat).
  - 3'b010 otherwise (reads with size>0).
- On wb_ack in XFER:
  - Read: ret_data = wb_dat_r registered; ret_data_valid[g] pulses the following cycle.
  - If cnt==0: drop cyc/stb, go IDLE.
  - Else: cnt--, wb_adr++ (mod 2^30, linear), stay XFER with stb held.
  - Write ack: completion is silent (no ret pulse); go IDLE.
- On wb_err in XFER:
  - Abort remaining beats; ret_err[g] pulses the following cycle; drop cyc/stb; go IDLE.
  - wb_err takes priority if ack and err are high together, and no data_valid is generated.
- Throughput: at least one idle cycle (IDLE) between transactions. Back-to-back requests from different requesters alternate under round-robin.
- Requests arriving during XFER are held off (no req_ack) until IDLE.
- ret_data holds its last value between beats; only ret_data_valid qualifies it.
- Maximum burst is 32 beats (size=31); the counter never underflows.

Test Plan:
- Single read, requester 0, addr 0x0000_1004, size 0; slave acks with 0xDEADBEEF after 2 waits:
  - req_ack[0] pulses in the request cycle; wb_adr=0x401, cti=111, sel=F.
  - ret_data_valid[0] with ret_data=0xDEADBEEF one cycle after ack; cyc low afterwards.
- Write, requester 1, addr 0x20, data 0x12345678, be 4'b0011:
  - wb_we=1, wb_adr=0x8, sel=0011, dat_w=0x12345678, cti=111.
  - After ack: no ret pulses; cyc drops.
- Read burst, size 3 at addr 0x100, data 0xA0..0xA3:
  - wb_adr 0x40,0x41,0x42,0x43; cti 010,010,010,111.
  - Four ret_data_valid[0] pulses, in order.
- Both requesters hold requests continuously from reset:
  - Grants order 0,1,0,1.
  - Each grant starts only after the previous ack plus one IDLE cycle.
- Burst size 3 with wb_err on beat 2:
  - One data_valid, then ret_err[0] pulse; cyc low; no further beats.
  - Next request is granted normally.
- rst_n asserted while wb_cyc=1 mid-burst:
  - cyc/stb/ack/valid go 0 asynchronously.
  - After release, the first grant goes to requester 0.
